// File: rtl/fnd_display_scheduler.sv
// Arbitrates the shared 4-digit FND between the main source and three overlay requesters.
// Optional FND_BLINK_EN adds blinking of blink_mask digits while an overlay is shown.
module fnd_display_scheduler #(
  parameter int CLK_HZ   = 100_000_000,
  parameter int HOLD_MS  = 2000,
  parameter int GAP_MS   = 50,
  parameter int BLINK_MS = 250
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic [15:0] main_value,
  input  logic [47:0] ovl_value,
  input  logic [2:0]  req,
  input  logic [3:0]  blink_mask,
  output logic [15:0] value,
  output logic [3:0]  blank,
  output logic [1:0]  active_src,
  output logic [2:0]  ack,
  output logic        busy
);
  // state   | meaning
  // MAIN    | main_value shown, waiting for any pending overlay
  // GAP     | all digits blanked between source switches
  // OVERLAY | overlay cur shown, hold timer running
  typedef enum logic [1:0] {S_MAIN, S_GAP, S_OVERLAY} state_t;

  localparam int DIV    = CLK_HZ / 1000;
  localparam int PS_W   = (DIV > 1) ? $clog2(DIV) : 1;
  localparam int HOLD_W = (HOLD_MS > 1) ? $clog2(HOLD_MS) : 1;
  localparam int GAP_W  = (GAP_MS > 1) ? $clog2(GAP_MS) : 1;
  localparam logic [PS_W-1:0]   PS_LAST   = PS_W'(DIV - 1);
  localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(HOLD_MS - 1);
  localparam logic [GAP_W-1:0]  GAP_LAST  = GAP_W'(GAP_MS - 1);

  function automatic logic [1:0] pick(input logic [2:0] p);
    if (p[2])      return 2'd2;
    else if (p[1]) return 2'd1;
    else           return 2'd0;
  endfunction

  function automatic logic [2:0] onehot(input logic [1:0] i);
    return 3'b001 << i;
  endfunction

  function automatic logic [2:0] higher(input logic [1:0] i);
    case (i)
      2'd0:    return 3'b110;
      2'd1:    return 3'b100;
      default: return 3'b000;
    endcase
  endfunction

  state_t            state_q, state_d;
  logic [1:0]        cur_q, cur_d;
  logic [2:0]        pending_q, pending_d;
  logic [PS_W-1:0]   ps_q, ps_d;
  logic [HOLD_W-1:0] hold_q, hold_d;
  logic [GAP_W-1:0]  gap_q, gap_d;
  logic [2:0]        ack_q, ack_d;
  logic [15:0]       value_q, value_d;
  logic [3:0]        blank_q, blank_d;
  logic [1:0]        src_q, src_d;
  logic              tick_ms, restart, leave, req_cur;
  logic [2:0]        nxt_pend;

  // Free-running millisecond prescaler, independent of the FSM
  assign tick_ms = (ps_q == PS_LAST);
  assign ps_d    = tick_ms ? '0 : ps_q + 1'b1;
  assign req_cur = |(req & onehot(cur_q));

  always_comb begin
    state_d   = state_q;
    cur_d     = cur_q;
    hold_d    = hold_q;
    gap_d     = gap_q;
    pending_d = pending_q | req;
    ack_d     = '0;
    restart   = 1'b0;
    leave     = 1'b0;
    nxt_pend  = pending_q;
    case (state_q)
      S_MAIN: begin
        if (|pending_q) begin
          cur_d = pick(pending_q);
          if (GAP_MS == 0) begin
            state_d = S_OVERLAY;
            restart = 1'b1;
          end else begin
            state_d = S_GAP;
            gap_d   = '0;
          end
        end
      end
      S_GAP: begin
        if (tick_ms) begin
          if (gap_q == GAP_LAST) begin
            if (|pending_q) begin
              state_d = S_OVERLAY;
              cur_d   = pick(pending_q);
              restart = 1'b1;
            end else begin
              state_d = S_MAIN;
            end
          end else begin
            gap_d = gap_q + 1'b1;
          end
        end
      end
      S_OVERLAY: begin
        if (tick_ms && hold_q == HOLD_LAST) begin
          ack_d = onehot(cur_q);
          // A request landing on the completion cycle keeps the overlay pending
          if (!req_cur) pending_d = pending_d & ~onehot(cur_q);
          leave    = 1'b1;
          nxt_pend = pending_d;
        end else if (|(pending_q & higher(cur_q))) begin
          leave = 1'b1;
        end else if (req_cur) begin
          restart = 1'b1;
        end else if (tick_ms) begin
          hold_d = hold_q + 1'b1;
        end
        if (leave) begin
          if (GAP_MS != 0) begin
            state_d = S_GAP;
            gap_d   = '0;
          end else if (|nxt_pend) begin
            cur_d   = pick(nxt_pend);
            restart = 1'b1;
          end else begin
            state_d = S_MAIN;
          end
        end
      end
      default: state_d = S_MAIN;
    endcase
    if (restart) hold_d = '0;
  end

`ifdef FND_BLINK_EN
  localparam int BLINK_W = (BLINK_MS > 1) ? $clog2(BLINK_MS) : 1;
  localparam logic [BLINK_W-1:0] BLINK_LAST = BLINK_W'(BLINK_MS - 1);
  logic [BLINK_W-1:0] blink_cnt_q, blink_cnt_d;
  logic               phase_on_q, phase_on_d;

  always_comb begin
    blink_cnt_d = blink_cnt_q;
    phase_on_d  = phase_on_q;
    if (restart) begin
      blink_cnt_d = '0;
      phase_on_d  = 1'b1;
    end else if (state_q == S_OVERLAY && tick_ms) begin
      if (blink_cnt_q == BLINK_LAST) begin
        blink_cnt_d = '0;
        phase_on_d  = ~phase_on_q;
      end else begin
        blink_cnt_d = blink_cnt_q + 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      blink_cnt_q <= '0;
      phase_on_q  <= 1'b1;
    end else begin
      blink_cnt_q <= blink_cnt_d;
      phase_on_q  <= phase_on_d;
    end
  end
`else
  logic blink_unused;
  assign blink_unused = ^{blink_mask, BLINK_MS[0]};
`endif

  always_comb begin
    value_d = value_q;
    blank_d = blank_q;
    src_d   = src_q;
    case (state_q)
      S_MAIN: begin
        value_d = main_value;
        blank_d = 4'b0000;
        src_d   = 2'd0;
      end
      S_GAP: blank_d = 4'b1111;
      S_OVERLAY: begin
        case (cur_q)
          2'd1:    value_d = ovl_value[31:16];
          2'd2:    value_d = ovl_value[47:32];
          default: value_d = ovl_value[15:0];
        endcase
        src_d = cur_q + 2'd1;
`ifdef FND_BLINK_EN
        blank_d = phase_on_q ? 4'b0000 : blink_mask;
`else
        blank_d = 4'b0000;
`endif
      end
      default: blank_d = 4'b0000;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q   <= S_MAIN;
      cur_q     <= 2'd0;
      pending_q <= '0;
      ps_q      <= '0;
      hold_q    <= '0;
      gap_q     <= '0;
      ack_q     <= '0;
      value_q   <= '0;
      blank_q   <= '0;
      src_q     <= '0;
    end else begin
      state_q   <= state_d;
      cur_q     <= cur_d;
      pending_q <= pending_d;
      ps_q      <= ps_d;
      hold_q    <= hold_d;
      gap_q     <= gap_d;
      ack_q     <= ack_d;
      value_q   <= value_d;
      blank_q   <= blank_d;
      src_q     <= src_d;
    end
  end

  assign value      = value_q;
  assign blank      = blank_q;
  assign active_src = src_q;
  assign ack        = ack_q;
  assign busy       = (state_q != S_MAIN);

endmodule
